// File: rtl/dac_spi_multi.sv
// dac_spi_multi
//   Serial front end for a 1- or 2-channel SPI DAC (MCP48x2-style 16-bit
//   frames). One accepted request shifts a frame for each enabled channel,
//   lowest channel first, and then pulses LDAC once so that every channel
//   updates at the same instant.
//
// Parameters
//   DATA_W  : DAC code width (8, 10 or 12)
//   NUM_CH  : number of channels (1 or 2)
//   CLK_DIV : clk cycles per SCLK half-period (>= 1)
//   BUF     : frame bit 14, Vref buffer select
//   GAIN    : frame bit 13, 1 = x1, 0 = x2
//
// Ports
//   clk, rst    : system clock, synchronous active-high reset
//   wr_data     : channel codes, channel k at [k*DATA_W +: DATA_W]
//   ch_enable   : per-channel update enable, captured at accept
//   wr_valid    : update request; accepted when wr_ready is high
//   wr_ready    : high while idle and out of reset
//   busy        : high whenever a request is being serviced
//   done        : one-cycle completion pulse
//   dac_sclk    : SPI clock, mode 0
//   dac_cs_n    : chip select, active low
//   dac_mosi    : serial data, MSB first
//   dac_ldac_n  : latch strobe, active low
module dac_spi_multi #(
  parameter int   DATA_W  = 10,
  parameter int   NUM_CH  = 2,
  parameter int   CLK_DIV = 2,
  parameter logic BUF     = 1'b1,
  parameter logic GAIN    = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] wr_data,
  input  logic [NUM_CH-1:0]        ch_enable,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     dac_sclk,
  output logic                     dac_cs_n,
  output logic                     dac_mosi,
  output logic                     dac_ldac_n
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WAIT_W = $clog2(2 * CLK_DIV + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [WAIT_W-1:0] HOLD_LAST = WAIT_W'(CLK_DIV - 1);
  // The LOAD cycle that follows the gap also keeps chip select high, so the
  // gap state itself stops one cycle short of the full inter-frame gap.
  localparam logic [WAIT_W-1:0] GAP_LAST  = WAIT_W'(2 * CLK_DIV - 2);
  localparam logic [WAIT_W-1:0] LDAC_LAST = WAIT_W'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, SHIFT, CS_HOLD, CS_GAP, LDAC, DONE
  } state_t;

  state_t                    state;
  logic [NUM_CH*DATA_W-1:0]  data_q;
  logic [NUM_CH-1:0]         pend;
  logic                      sent_any;
  logic [15:0]               frame_q;
  logic [3:0]                bit_cnt;
  logic [DIV_W-1:0]          div_cnt;
  logic [WAIT_W-1:0]         wait_cnt;

  function automatic logic [15:0] build_frame(input logic ch,
                                              input logic [DATA_W-1:0] code);
    logic [11:0] low;
    low = '0;
    low[11 -: DATA_W] = code;
    return {ch, BUF, GAIN, 1'b1, low};
  endfunction

  // Lowest-numbered channel still pending
  logic              sel_ok;
  logic              sel_ch;
  logic [NUM_CH-1:0] sel_mask;
  logic [DATA_W-1:0] sel_code;
  logic [15:0]       next_frame;

  always_comb begin
    sel_ok   = 1'b0;
    sel_ch   = 1'b0;
    sel_mask = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (pend[k]) begin
        sel_ok      = 1'b1;
        sel_ch      = 1'(k);
        sel_mask    = '0;
        sel_mask[k] = 1'b1;
      end
    end
    sel_code   = data_q[int'(sel_ch) * DATA_W +: DATA_W];
    next_frame = build_frame(sel_ch, sel_code);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dac_sclk   <= 1'b0;
      dac_cs_n   <= 1'b1;
      dac_mosi   <= 1'b0;
      dac_ldac_n <= 1'b1;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      wait_cnt   <= '0;
      pend       <= '0;
      sent_any   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          wr_ready <= 1'b1;
          if (wr_valid && wr_ready) begin
            data_q   <= wr_data;
            pend     <= ch_enable;
            sent_any <= 1'b0;
            wr_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (sel_ok) begin
            // Chip select falls together with the first data bit
            frame_q  <= next_frame;
            dac_mosi <= next_frame[15];
            dac_cs_n <= 1'b0;
            dac_sclk <= 1'b0;
            bit_cnt  <= 4'd15;
            div_cnt  <= '0;
            pend     <= pend & ~sel_mask;
            sent_any <= 1'b1;
            state    <= SHIFT;
          end else if (sent_any) begin
            dac_ldac_n <= 1'b0;
            wait_cnt   <= '0;
            state      <= LDAC;
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!dac_sclk) begin
              dac_sclk <= 1'b1;
            end else begin
              // End of a bit: SCLK falls and the next bit is presented
              dac_sclk <= 1'b0;
              if (bit_cnt == 4'd0) begin
                wait_cnt <= '0;
                state    <= CS_HOLD;
              end else begin
                bit_cnt  <= bit_cnt - 4'd1;
                dac_mosi <= frame_q[bit_cnt - 4'd1];
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        CS_HOLD: begin
          if (wait_cnt == HOLD_LAST) begin
            dac_cs_n <= 1'b1;
            dac_mosi <= 1'b0;
            wait_cnt <= '0;
            state    <= CS_GAP;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        CS_GAP: begin
          if (wait_cnt == GAP_LAST) begin
            wait_cnt <= '0;
            state    <= LOAD;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        LDAC: begin
          if (wait_cnt == LDAC_LAST) begin
            dac_ldac_n <= 1'b1;
            wait_cnt   <= '0;
            done       <= 1'b1;
            state      <= DONE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        DONE: begin
          busy     <= 1'b0;
          wr_ready <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dac_spi_multi.md
DAC_SPI_MULTI -- requirements
Module: dac_spi_multi

Interface
REQ-001 SHALL have parameter DATA_W, default 10, DAC resolution in bits; legal values 8, 10, 12.
REQ-002 SHALL have parameter NUM_CH, default 2, number of DAC channels; legal values 1, 2.
REQ-003 SHALL have parameter CLK_DIV, default 2, clk cycles per SCLK half-period; legal values 1 and above.
REQ-004 SHALL have parameter BUF, default 1'b1, frame bit 14 (1 = Vref buffered).
REQ-005 SHALL have parameter GAIN, default 1'b1, frame bit 13 (1 = x1, 0 = x2).
REQ-006 SHALL have port clk, input, 1, system clock; all logic runs on its rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port wr_data, input, NUM_CH*DATA_W, channel codes; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-009 SHALL have port ch_enable, input, NUM_CH, per-channel update enable, sampled at accept.
REQ-010 SHALL have port wr_valid, input, 1, request to start an update.
REQ-011 SHALL have port wr_ready, output, 1, high only in IDLE while not in reset.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-013 SHALL have port done, output, 1, one-cycle pulse when an update completes.
REQ-014 SHALL have port dac_sclk, output, 1, SPI clock, mode 0, idles low.
REQ-015 SHALL have port dac_cs_n, output, 1, active-low chip select.
REQ-016 SHALL have port dac_mosi, output, 1, serial data, MSB first.
REQ-017 SHALL have port dac_ldac_n, output, 1, active-low latch strobe.

Function
REQ-018 A transfer SHALL be accepted when wr_valid and wr_ready are both high; wr_data and ch_enable SHALL be captured on that cycle, and later changes to them SHALL NOT affect the update in progress.
REQ-019 wr_valid SHALL be ignored when wr_ready is low.
REQ-020 The FSM SHALL have the states IDLE, LOAD, SHIFT, CS_HOLD, CS_GAP, LDAC and DONE.
REQ-021 LOAD SHALL select the lowest-numbered enabled channel not yet sent; if none remains, it SHALL go to LDAC when at least one channel was sent, otherwise to DONE.
REQ-022 The frame SHALL be 16 bits: bit15 = channel index (always 0 when NUM_CH=1), bit14 = BUF, bit13 = GAIN, bit12 = 1, bits[11 -: DATA_W] = code, with the remaining low bits 0.
REQ-023 On entry to SHIFT, dac_cs_n SHALL fall and dac_mosi SHALL present bit15 in the same cycle.
REQ-024 Each bit SHALL last 2*CLK_DIV cycles: CLK_DIV cycles with dac_sclk low, then CLK_DIV cycles with dac_sclk high.
REQ-025 dac_mosi SHALL change only at bit boundaries; the DAC samples it on the rising edge.
REQ-026 After the high phase of bit 0, dac_sclk SHALL return low and the FSM SHALL stay in CS_HOLD for CLK_DIV cycles with dac_cs_n low; dac_cs_n low time SHALL total 33*CLK_DIV cycles per frame.
REQ-027 CS_GAP SHALL hold dac_cs_n high for 2*CLK_DIV cycles and then return to LOAD.
REQ-028 LDAC SHALL drive dac_ldac_n low for 2*CLK_DIV cycles, so all channels update simultaneously.
REQ-029 DONE SHALL last one cycle with done=1; the FSM SHALL then enter IDLE, and wr_ready SHALL be high on the following cycle.
REQ-030 An accept with ch_enable all zero SHALL produce done in the cycle after LOAD, with no activity on dac_cs_n, dac_sclk or dac_ldac_n.
REQ-031 The bit counter SHALL count 15 down to 0 with no wrap; the divider counter SHALL count 0 to CLK_DIV-1.

Reset
REQ-032 While rst is high, outputs SHALL be: dac_cs_n=1, dac_sclk=0, dac_mosi=0, dac_ldac_n=1, busy=0, done=0, wr_ready=0; the FSM SHALL be in IDLE and the counters at 0.
REQ-033 rst asserted mid-frame SHALL abort the frame at the next clk edge, with no done pulse and no LDAC strobe.
REQ-034 wr_ready SHALL go high on the first cycle after rst deasserts.

Verification
REQ-035 Bench SHALL cover: DATA_W=10, CLK_DIV=2, ch_enable=2'b01, ch0=10'h2AA -> one frame 0x7AA8, dac_cs_n low for 66 cycles, 16 SCLK rising edges, one ldac pulse 4 cycles wide, then done.
REQ-036 Bench SHALL cover: ch_enable=2'b11, ch0=10'h2AA, ch1=10'h155 -> frames 0x7AA8 then 0xF554, a 4-cycle dac_cs_n high gap between them, then a single ldac pulse.
REQ-037 Bench SHALL cover: ch_enable=2'b00 -> done pulse with dac_cs_n, dac_sclk and dac_ldac_n constant throughout.
REQ-038 Bench SHALL cover: rst asserted after the 7th SCLK rising edge -> next cycle dac_cs_n=1, dac_sclk=0, busy=0, and no done pulse.
REQ-039 Bench SHALL cover: wr_valid held high and wr_data changed while busy -> no second accept, the frame keeps the captured data, and the next accept occurs the cycle after done.
REQ-040 Bench SHALL cover: DATA_W=12, NUM_CH=1, CLK_DIV=1, code 12'hFFF -> frame 0x7FFF with bit15=0 and dac_cs_n low for 33 cycles.
